uart_cmd_host: RTL

- Host-side initiator for the UART PSRAM command protocol.
- Takes one parallel read or write request, serializes it into the command frame, and sends it through the byte-level interface of the existing `uart` block.
- Waits for the single response byte the PSRAM bridge returns after every command, with a timeout.
- Used on a second board or in the loopback bench to drive the PSRAM bridge.

---
 rtl/uart_cmd_pkg.sv | 32 +++
 rtl/uart_cmd_host.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared opcodes, state/command types and frame byte mux for uart_cmd_host
package uart_cmd_pkg;

   localparam logic [7:0] OP_READ      = 8'h00;
   localparam logic [7:0] OP_WRITE     = 8'h01;
   localparam logic [2:0] FRAME_LEN_RD = 3'd4;
   localparam logic [2:0] FRAME_LEN_WR = 3'd6;

   typedef enum logic [2:0] {IDLE, SEND, GUARD, WAIT_RSP, DONE} uart_cmd_state_t;

   typedef struct packed {
      logic        we;
      logic [23:0] addr;
      logic [15:0] wdat;
   } uart_cmd_t;

   // Byte order on the wire: opcode, address LSB first, then write data LSB first.
   function automatic logic [7:0] frame_byte(input uart_cmd_t cmd, input logic [2:0] idx);
      logic [7:0] b;
      case (idx)
         3'd0:    b = cmd.we ? OP_WRITE : OP_READ;
         3'd1:    b = cmd.addr[7:0];
         3'd2:    b = cmd.addr[15:8];
         3'd3:    b = cmd.addr[23:16];
         3'd4:    b = cmd.wdat[7:0];
         3'd5:    b = cmd.wdat[15:8];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/uart_cmd_host.sv
// rtl/uart_cmd_host.sv - serialises one PSRAM read/write request onto the uart byte port and awaits the reply
// Optional resend after a response timeout when UART_CMD_RETRY_EN is defined.
module uart_cmd_host
   import uart_cmd_pkg::*;
#(
   parameter int TIMEOUT_US = 2000,
   parameter int GAP_CYCLES = 4,
   parameter int MAX_RETRY  = 1
) (
   input  logic        clk_out,
   input  logic        arst_n,
   input  logic        tick_1us,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_we,
   input  logic [23:0] cmd_addr,
   input  logic [15:0] cmd_wdat,
   output logic        uart_tx_write,
   output logic [7:0]  uart_tx_data,
   input  logic        uart_tx_busy,
   input  logic        uart_rx_valid,
   input  logic [7:0]  uart_rx_data,
   output logic        uart_rx_read,
   output logic        rsp_valid,
   output logic [7:0]  rsp_data,
   output logic        rsp_timeout
);

   localparam logic [15:0] TO_LIM  = 16'(TIMEOUT_US);
   localparam logic [15:0] GAP_LIM = 16'(GAP_CYCLES);

   uart_cmd_state_t state_q, state_d;
   uart_cmd_t       cmd_q, cmd_d;
   logic [2:0]      idx_q, idx_d;
   logic [15:0]     gap_q, gap_d;
   logic            hold_q, hold_d;
   logic [15:0]     to_q, to_d;
   logic            tx_write_q, tx_write_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic [7:0]      rsp_data_q, rsp_data_d;
   logic            rsp_to_q, rsp_to_d;
   logic [2:0]      frame_len;
`ifdef UART_CMD_RETRY_EN
   localparam logic [7:0] RETRY_LIM = 8'(MAX_RETRY);
   logic [7:0]      retry_q, retry_d;
`endif

   assign frame_len     = cmd_q.we ? FRAME_LEN_WR : FRAME_LEN_RD;
   assign cmd_ready     = (state_q == IDLE);
   assign rsp_valid     = (state_q == DONE);
   // Every received byte is popped; outside WAIT_RSP it is simply discarded.
   assign uart_rx_read  = uart_rx_valid;
   assign uart_tx_write = tx_write_q;
   assign uart_tx_data  = tx_data_q;
   assign rsp_data      = rsp_data_q;
   assign rsp_timeout   = rsp_to_q;

   always_ff @(posedge clk_out or negedge arst_n) begin
      if (!arst_n) begin
         state_q    <= IDLE;
         cmd_q      <= '0;
         idx_q      <= 3'd0;
         gap_q      <= 16'd0;
         hold_q     <= 1'b0;
         to_q       <= 16'd0;
         tx_write_q <= 1'b0;
         tx_data_q  <= 8'h00;
         rsp_data_q <= 8'h00;
         rsp_to_q   <= 1'b0;
`ifdef UART_CMD_RETRY_EN
         retry_q    <= 8'd0;
`endif
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         idx_q      <= idx_d;
         gap_q      <= gap_d;
         hold_q     <= hold_d;
         to_q       <= to_d;
         tx_write_q <= tx_write_d;
         tx_data_q  <= tx_data_d;
         rsp_data_q <= rsp_data_d;
         rsp_to_q   <= rsp_to_d;
`ifdef UART_CMD_RETRY_EN
         retry_q    <= retry_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      cmd_d      = cmd_q;
      idx_d      = idx_q;
      gap_d      = gap_q;
      hold_d     = 1'b0;
      to_d       = to_q;
      tx_write_d = 1'b0;
      tx_data_d  = tx_data_q;
      rsp_data_d = rsp_data_q;
      rsp_to_d   = rsp_to_q;
`ifdef UART_CMD_RETRY_EN
      retry_d    = retry_q;
`endif
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               cmd_d   = {cmd_we, cmd_addr, cmd_wdat};
               idx_d   = 3'd0;
               state_d = SEND;
`ifdef UART_CMD_RETRY_EN
               retry_d = 8'd0;
`endif
            end
         end
         SEND: begin
            if (!uart_tx_busy) begin
               tx_data_d  = frame_byte(cmd_q, idx_q);
               tx_write_d = 1'b1;
               idx_d      = idx_q + 3'd1;
               gap_d      = 16'd0;
               hold_d     = 1'b1;
               state_d    = GUARD;
            end
         end
         GUARD: begin
            // First GUARD cycle ignores busy: the uart only raises it after seeing the strobe.
            if (hold_q) begin
               gap_d = 16'd0;
            end else if (uart_tx_busy) begin
               gap_d = 16'd0;
            end else if (gap_q == GAP_LIM) begin
               if (idx_q == frame_len) begin
                  to_d    = 16'd0;
                  state_d = WAIT_RSP;
               end else begin
                  state_d = SEND;
               end
            end else begin
               gap_d = gap_q + 16'd1;
            end
         end
         WAIT_RSP: begin
            if (uart_rx_valid) begin
               rsp_data_d = uart_rx_data;
               rsp_to_d   = 1'b0;
               state_d    = DONE;
            end else if (to_q == TO_LIM) begin
`ifdef UART_CMD_RETRY_EN
               if (retry_q < RETRY_LIM) begin
                  retry_d = retry_q + 8'd1;
                  idx_d   = 3'd0;
                  state_d = SEND;
               end else begin
                  rsp_data_d = 8'h00;
                  rsp_to_d   = 1'b1;
                  state_d    = DONE;
               end
`else
               rsp_data_d = 8'h00;
               rsp_to_d   = 1'b1;
               state_d    = DONE;
`endif
            end else if (tick_1us && (to_q != 16'hFFFF)) begin
               to_d = to_q + 16'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule
